pipe_hazard_ctrl: RTL

Parametrised pipeline control unit for the pipelined CPU. It replaces the fixed load-use detector and fixed two-source forwarding selector. A DEPTH-entry scoreboard tracks in-flight writers from EX to WB. From it the block derives stall, bubble, flush and registered forwarding selects for any stage count and any load latency.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_src_match.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types, forward-select encodings and default parameters for pipe_hazard_ctrl.
package pipe_pkg;
    localparam int DEPTH_DEF    = 3;
    localparam int RA_W_DEF     = 5;
    localparam int LOAD_LAT_DEF = 1;
    localparam int BR_STAGE_DEF = 1;

    // Entry fields are sized for the largest supported configuration
    localparam int RA_W_MAX  = 16;
    localparam int CNT_W_MAX = 4;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [RA_W_MAX-1:0]  waddr;
        logic [CNT_W_MAX-1:0] rdy_cnt;
    } sb_entry_t;

    // Retire-latch select equals the scoreboard depth
    function automatic int fwd_retire(input int depth);
        return depth;
    endfunction

    // Entry k feeds EX through the output register of stage k, encoded as k+1
    function automatic int fwd_sel(input logic hit, input int idx);
        return hit ? idx + 1 : FWD_RF;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage request and hazard-control response bundle.
interface pipe_hazard_ctrl_if #(
    parameter int DEPTH = pipe_pkg::DEPTH_DEF,
    parameter int RA_W  = pipe_pkg::RA_W_DEF,
    parameter int FS_W  = $clog2(DEPTH + 1)
);
    logic            id_valid_i;
    logic [RA_W-1:0] id_rs_i;
    logic [RA_W-1:0] id_rt_i;
    logic            id_use_rs_i;
    logic            id_use_rt_i;
    logic            id_wr_i;
    logic [RA_W-1:0] id_waddr_i;
    logic            id_load_i;
    logic            redirect_i;
    logic            stall_o;
    logic            bubble_o;
    logic            flush_o;
    logic [FS_W-1:0] fwd_a_o;
    logic [FS_W-1:0] fwd_b_o;
    logic [DEPTH-1:0] stage_valid_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_wr_i, id_waddr_i, id_load_i, redirect_i,
        input  stall_o, bubble_o, flush_o, fwd_a_o, fwd_b_o, stage_valid_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_wr_i, id_waddr_i, id_load_i, redirect_i,
        output stall_o, bubble_o, flush_o, fwd_a_o, fwd_b_o, stage_valid_o
    );
endinterface

// File: rtl/pipe_src_match.sv
// pipe_src_match: finds the youngest in-flight writer of one source register.
module pipe_src_match import pipe_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int RA_W  = RA_W_DEF,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic                 use_src,
    input  logic [RA_W-1:0]      src,
    input  sb_entry_t            sb [DEPTH],
    output logic                 hit,
    output logic [IW-1:0]        idx,
    output logic [CNT_W_MAX-1:0] rdy_cnt
);
    // Scan oldest to youngest so the youngest matching writer wins; $0 never matches
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        rdy_cnt = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (use_src && src != '0 && sb[i].valid && sb[i].wr &&
                sb[i].waddr == RA_W_MAX'(src)) begin
                hit     = 1'b1;
                idx     = IW'(i);
                rdy_cnt = sb[i].rdy_cnt;
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-driven stall, bubble, flush and forward-select control.
// Defining PIPE_HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl import pipe_pkg::*; #(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int RA_W     = RA_W_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int BR_STAGE = BR_STAGE_DEF,
    parameter int FS_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);
    localparam int IW = $clog2(DEPTH);

    sb_entry_t            sb  [DEPTH];
    sb_entry_t            nxt [DEPTH];
    logic                 hit_a, hit_b, hazard, stall, advance;
    logic [IW-1:0]        idx_a, idx_b;
    logic [CNT_W_MAX-1:0] rdy_a, rdy_b;
    logic [FS_W-1:0]      fwd_a, fwd_b;
    logic [DEPTH-1:0]     stage_valid;

    pipe_src_match #(.DEPTH(DEPTH), .RA_W(RA_W)) u_match_a (
        .use_src(bus.id_use_rs_i), .src(bus.id_rs_i), .sb(sb),
        .hit(hit_a), .idx(idx_a), .rdy_cnt(rdy_a)
    );

    pipe_src_match #(.DEPTH(DEPTH), .RA_W(RA_W)) u_match_b (
        .use_src(bus.id_use_rt_i), .src(bus.id_rt_i), .sb(sb),
        .hit(hit_b), .idx(idx_b), .rdy_cnt(rdy_b)
    );

    // Hazard when a used source's youngest producer is not yet forwardable; redirect overrides it
    always_comb begin
        hazard  = bus.id_valid_i && ((hit_a && rdy_a != '0) || (hit_b && rdy_b != '0));
        stall   = hazard && !bus.redirect_i;
        advance = bus.id_valid_i && !hazard && !bus.redirect_i;
    end

    assign bus.stall_o       = stall;
    assign bus.bubble_o      = stall;
    assign bus.flush_o       = bus.redirect_i;
    assign bus.fwd_a_o       = fwd_a;
    assign bus.fwd_b_o       = fwd_b;
    assign bus.stage_valid_o = stage_valid;

    // Next scoreboard: ID or a bubble enters EX; older entries shift, age, and die if younger than a redirect
    always_comb begin
        nxt[0] = '0;
        if (advance) begin
            nxt[0].valid   = 1'b1;
            nxt[0].wr      = bus.id_wr_i;
            nxt[0].waddr   = RA_W_MAX'(bus.id_waddr_i);
            nxt[0].rdy_cnt = bus.id_load_i ? CNT_W_MAX'(LOAD_LAT) : '0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            nxt[i]       = sb[i-1];
            nxt[i].valid = sb[i-1].valid && !(bus.redirect_i && i <= BR_STAGE);
            if (sb[i-1].rdy_cnt != '0)
                nxt[i].rdy_cnt = sb[i-1].rdy_cnt - 1'b1;
        end
    end

    // Expose per-entry valid bits
    always_comb begin
        stage_valid = '0;
        for (int i = 0; i < DEPTH; i++)
            stage_valid[i] = sb[i].valid;
    end

    // Scoreboard state and forward selects registered for the instruction entering EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                sb[i] <= '0;
            fwd_a <= '0;
            fwd_b <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                sb[i] <= nxt[i];
            fwd_a <= advance ? FS_W'(fwd_sel(hit_a, int'(idx_a))) : FS_W'(FWD_RF);
            fwd_b <= advance ? FS_W'(fwd_sel(hit_b, int'(idx_b))) : FS_W'(FWD_RF);
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Saturating counts of stall and flush cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (bus.redirect_i && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`endif
endmodule
